// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered 8-bit adder among NREQ requesters.
// Operands are registered in front of the adder and the sum behind it; results return ID-tagged.

module adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] carry;

  // Ripple-carry chain
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < 8; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[8];

endmodule

module adder_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*8-1:0]  req_a,
  input  logic [NREQ*8-1:0]  req_b,
  output logic [NREQ-1:0]    req_ready,
  input  logic               pause,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [7:0]         rsp_sum,
  output logic               rsp_cout,
  output logic               busy,
  output logic [7:0]         carry_cnt
);

  localparam int unsigned DW      = 8;
  localparam int unsigned CNT_MAX = 255;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  sum;
    logic           cout;
  } res_t;

  logic [IDW-1:0] ptr_q, ptr_d;
  op_t            s1_q, s1_d;
  logic           v1_q, v1_d;
  res_t           s2_q, s2_d;
  logic           v2_q, v2_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic           busy_q;

  logic           gnt_found_c;
  logic [IDW-1:0] gnt_id_c;
  logic           xfer_c;
  logic [DW-1:0]  sel_a_c, sel_b_c;
  logic [DW-1:0]  add_sum;
  logic           add_cout;

  // First valid requester at or after the pointer, wrapping modulo NREQ
  always_comb begin
    logic [IDW-1:0] cand;
    cand        = '0;
    gnt_found_c = 1'b0;
    gnt_id_c    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IDW'((32'(ptr_q) + off) % NREQ);
      if (!gnt_found_c && req_valid[cand]) begin
        gnt_found_c = 1'b1;
        gnt_id_c    = cand;
      end
    end
  end

  assign xfer_c = gnt_found_c & ~pause & ~rst;

  // One-hot grant and operand select for the winning requester
  always_comb begin
    req_ready = '0;
    sel_a_c   = '0;
    sel_b_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_id_c) begin
        sel_a_c = req_a[DW*i +: DW];
        sel_b_c = req_b[DW*i +: DW];
      end
    end
    if (xfer_c) begin
      req_ready[gnt_id_c] = 1'b1;
    end
  end

  adder_8bit u_adder (
    .a_i    (s1_q.a),
    .b_i    (s1_q.b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    ptr_d = ptr_q;
    s1_d  = s1_q;
    v1_d  = xfer_c;
    if (xfer_c) begin
      ptr_d   = (gnt_id_c == IDW'(NREQ - 1)) ? '0 : gnt_id_c + IDW'(1);
      s1_d.id = gnt_id_c;
      s1_d.a  = sel_a_c;
      s1_d.b  = sel_b_c;
    end
    s2_d.id   = s1_q.id;
    s2_d.sum  = add_sum;
    s2_d.cout = add_cout;
    v2_d      = v1_q;
    // Count carries as they enter the result register, saturating
    cnt_d = cnt_q;
    if (v1_q && add_cout && (cnt_q != DW'(CNT_MAX))) begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      s1_q   <= '0;
      v1_q   <= 1'b0;
      s2_q   <= '0;
      v2_q   <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      s1_q   <= s1_d;
      v1_q   <= v1_d;
      s2_q   <= s2_d;
      v2_q   <= v2_d;
      cnt_q  <= cnt_d;
      busy_q <= v1_d | v2_d;
    end
  end

  assign rsp_valid = v2_q;
  assign rsp_id    = s2_q.id;
  assign rsp_sum   = s2_q.sum;
  assign rsp_cout  = s2_q.cout;
  assign busy      = busy_q;
  assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.

module tb_adder_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              pause = 1'b0;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_sum;
  logic              rsp_cout;
  logic              busy;
  logic [7:0]        carry_cnt;

  logic [7:0] a_arr [NREQ];
  logic [7:0] b_arr [NREQ];

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = a_arr[i];
      req_b[8*i +: 8] = b_arr[i];
    end
  end

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .pause     (pause),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy),
    .carry_cnt (carry_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected responses are scheduled by the edge on which they appear
  typedef struct {
    int due;
    int id;
    int sum;
    int cout;
  } exp_t;

  exp_t q[$];
  int   m_ptr    = 0;
  int   m_cnt    = 0;
  int   edge_n   = 0;
  int   last_gnt = -1;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p, input logic pz, input logic r);
    if (pz || r) return -1;
    for (int off = 0; off < NREQ; off++) begin
      int i = (p + off) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    int   mg;
    int   s;
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_ptr    = 0;
        m_cnt    = 0;
        last_gnt = -1;
      end else begin
        edge_n++;
        while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
        if (q.size() > 0 && q[0].due == edge_n && q[0].cout != 0 && m_cnt < 255) m_cnt++;
        mg       = rr_pick(req_valid, m_ptr, pause, 1'b0);
        last_gnt = mg;
        if (mg >= 0) begin
          s      = int'(a_arr[mg]) + int'(b_arr[mg]);
          e.due  = edge_n + 1;
          e.id   = mg;
          e.sum  = s % 256;
          e.cout = (s > 255) ? 1 : 0;
          q.push_back(e);
          m_ptr = (mg + 1) % NREQ;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  initial begin
    int              eg;
    logic [NREQ-1:0] er;
    int              ev;
    forever begin
      @(negedge clk);
      eg = rr_pick(req_valid, m_ptr, pause, rst);
      er = (eg >= 0) ? (NREQ'(1) << eg) : '0;
      check("req_ready", int'(req_ready), int'(er));
      ev = (!rst && q.size() > 0 && q[0].due == edge_n) ? 1 : 0;
      check("rsp_valid", int'(rsp_valid), ev);
      if (ev != 0) begin
        check("rsp_id", int'(rsp_id), q[0].id);
        check("rsp_sum", int'(rsp_sum), q[0].sum);
        check("rsp_cout", int'(rsp_cout), q[0].cout);
      end
      if (rst) begin
        check("rst rsp_id", int'(rsp_id), 0);
        check("rst rsp_sum", int'(rsp_sum), 0);
        check("rst rsp_cout", int'(rsp_cout), 0);
      end
      check("busy", int'(busy), (!rst && q.size() > 0) ? 1 : 0);
      check("carry_cnt", int'(carry_cnt), m_cnt);
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    repeat (2) tick();
    check("reset rsp_valid", int'(rsp_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset carry_cnt", int'(carry_cnt), 0);
    req_valid = '1;
    #1;
    check("reset req_ready", int'(req_ready), 0);
    req_valid = '0;
    rst = 1'b0;

    // Single request from requester 2
    a_arr[2] = 8'h35;
    b_arr[2] = 8'h4A;
    req_valid = 4'b0100;
    #1;
    check("single ready", int'(req_ready), 4'b0100);
    tick();
    req_valid = '0;
    tick();
    check("single rsp_valid", int'(rsp_valid), 1);
    check("single rsp_id", int'(rsp_id), 2);
    check("single rsp_sum", int'(rsp_sum), 8'h7F);
    check("single rsp_cout", int'(rsp_cout), 0);
    tick();
    check("single pulse end", int'(rsp_valid), 0);

    // Carry and wrap, then saturate the carry counter
    a_arr[0] = 8'hFF;
    b_arr[0] = 8'h01;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check("carry rsp_sum", int'(rsp_sum), 0);
    check("carry rsp_cout", int'(rsp_cout), 1);
    check("carry cnt one", int'(carry_cnt), 1);
    req_valid = 4'b0001;
    repeat (300) tick();
    req_valid = '0;
    repeat (3) tick();
    check("carry cnt sat", int'(carry_cnt), 255);
    check("carry drained", int'(busy), 0);

    // Fairness from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_arr[1] = 8'h10; b_arr[1] = 8'h20;
    a_arr[3] = 8'hC0; b_arr[3] = 8'h50;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("fair grant", int'(req_ready), 1 << (c % 4));
      tick();
    end
    req_valid = '0;
    check("fair rsp id a", int'(rsp_id), 2);
    tick();
    check("fair rsp id b", int'(rsp_id), 3);
    check("fair rsp sum b", int'(rsp_sum), 8'h10);

    // Pointer wrap and skip
    req_valid = 4'b1000;
    #1;
    check("skip grant3", int'(req_ready), 4'b1000);
    tick();
    req_valid = 4'b0110;
    #1;
    check("skip grant1", int'(req_ready), 4'b0010);
    tick();
    req_valid = 4'b0100;
    #1;
    check("skip grant2", int'(req_ready), 4'b0100);
    tick();

    // Pause with in-flight results
    req_valid = '1;
    repeat (2) tick();
    pause = 1'b1;
    #1;
    check("pause ready", int'(req_ready), 0);
    tick();
    check("pause busy1", int'(busy), 1);
    tick();
    check("pause busy0", int'(busy), 0);
    pause = 1'b0;
    #1;
    check("resume grant", int'(req_ready), 4'b0010);
    tick();

    // Reset mid-flight
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("midrst rsp_valid", int'(rsp_valid), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst carry_cnt", int'(carry_cnt), 0);
    repeat (2) tick();
    req_valid = '1;
    #1;
    check("midrst ready held", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    check("midrst first grant", int'(req_ready), 4'b0001);
    tick();
    req_valid = '0;
    tick();

    // Randomized traffic with the hold-until-granted rule
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && last_gnt != i)) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          if ($urandom_range(0, 3) == 0) begin
            a_arr[i] = 8'hFF;
            b_arr[i] = 8'($urandom_range(1, 255));
          end else begin
            a_arr[i] = 8'($urandom);
            b_arr[i] = 8'($urandom);
          end
        end
      end
      pause = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    pause = 1'b0;
    req_valid = '0;
    repeat (4) tick();
    check("final busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
